// File: rtl/iis_stream_ctrl.sv
// iis_stream_ctrl: start/stop sequencer and sample-stream bridge for one iis
// instance. Pushes TX stereo samples into the iis TX FIFO, drains the RX FIFO
// into a one-entry output register, and counts underruns/overruns.
module iis_stream_ctrl #(
  parameter int CLR_CYCLES    = 4,
  parameter int PREFILL       = 2,
  parameter int FLUSH_TIMEOUT = 65535,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic [2:0]       state_o,
  input  logic             tx_s_valid,
  output logic             tx_s_ready,
  input  logic [31:0]      tx_s_l,
  input  logic [31:0]      tx_s_r,
  output logic             rx_m_valid,
  input  logic             rx_m_ready,
  output logic [31:0]      rx_m_l,
  output logic [31:0]      rx_m_r,
  output logic             tx_data_fill,
  output logic             tx_data_clear,
  output logic [31:0]      tx_data_l,
  output logic [31:0]      tx_data_r,
  input  logic             tx_data_l_full,
  input  logic             tx_data_r_full,
  input  logic             tx_data_l_empty,
  input  logic             tx_data_r_empty,
  output logic             rx_data_drain,
  output logic             rx_data_clear,
  input  logic [31:0]      rx_data_l,
  input  logic [31:0]      rx_data_r,
  input  logic             rx_data_l_empty,
  input  logic             rx_data_r_empty,
  input  logic             rx_data_l_full,
  input  logic             rx_data_r_full,
  output logic             enable_o,
  output logic [CNT_W-1:0] underrun_cnt,
  output logic [CNT_W-1:0] overrun_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_PREFILL = 3'd2,
    S_RUN     = 3'd3,
    S_FLUSH   = 3'd4
  } state_t;

  localparam int CLR_W = $clog2(CLR_CYCLES + 1);
  localparam int PF_W  = $clog2(PREFILL + 1);
  localparam int FL_W  = $clog2(FLUSH_TIMEOUT + 1);

  state_t          state, state_n;
  logic [CLR_W-1:0] clr_cnt;
  logic [PF_W-1:0]  pf_cnt;
  logic [FL_W-1:0]  fl_cnt;

  logic tx_full_any, tx_both_empty, rx_empty_any, rx_full_any;
  logic tx_fire, rx_pop, rx_consume;
  logic tx_emp_q, rx_full_q;

  assign tx_full_any   = tx_data_l_full | tx_data_r_full;
  assign tx_both_empty = tx_data_l_empty & tx_data_r_empty;
  assign rx_empty_any  = rx_data_l_empty | rx_data_r_empty;
  assign rx_full_any   = rx_data_l_full | rx_data_r_full;

  // Push gating: ready is suppressed while the fill pulse is high, which
  // caps the push rate at one sample every two cycles.
  assign tx_s_ready = ((state == S_PREFILL) || (state == S_RUN)) &&
                      !tx_full_any && !tx_data_fill;
  assign tx_fire    = tx_s_valid & tx_s_ready;

  assign rx_consume = rx_m_valid & rx_m_ready;
  assign rx_pop     = ((state == S_RUN) || (state == S_FLUSH)) && !rx_empty_any &&
                      !rx_data_drain && (!rx_m_valid || rx_consume);

  assign busy          = (state != S_IDLE);
  assign state_o       = state;
  assign enable_o      = (state == S_RUN) || (state == S_FLUSH);
  assign tx_data_clear = (state == S_IDLE) || (state == S_CLEAR);
  assign rx_data_clear = (state == S_IDLE) || (state == S_CLEAR);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state: stop always beats start; FLUSH ends on drained TX or timeout
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (start && !stop) state_n = S_CLEAR;
      S_CLEAR: begin
        if (stop)                                   state_n = S_IDLE;
        else if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) state_n = S_PREFILL;
      end
      S_PREFILL: begin
        if (stop)                                   state_n = S_IDLE;
        else if (tx_full_any ||
                 (tx_fire && pf_cnt == PF_W'(PREFILL - 1)))
                                                    state_n = S_RUN;
      end
      S_RUN:     if (stop) state_n = S_FLUSH;
      S_FLUSH: begin
        if (tx_both_empty || fl_cnt == FL_W'(FLUSH_TIMEOUT - 1)) state_n = S_IDLE;
      end
      default:   state_n = S_IDLE;
    endcase
  end

  // Sequencing counters: clear length, prefill pushes, flush duration
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clr_cnt <= '0;
      pf_cnt  <= '0;
      fl_cnt  <= '0;
    end else begin
      if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      else                  clr_cnt <= '0;
      if (state == S_IDLE)  pf_cnt <= '0;
      else if (state == S_PREFILL && tx_fire) pf_cnt <= pf_cnt + 1'b1;
      if (state == S_FLUSH) fl_cnt <= fl_cnt + 1'b1;
      else                  fl_cnt <= '0;
    end
  end

  // TX push: register sample and pulse fill in the same cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_data_fill <= 1'b0;
      tx_data_l    <= '0;
      tx_data_r    <= '0;
    end else begin
      tx_data_fill <= tx_fire;
      if (tx_fire) begin
        tx_data_l <= tx_s_l;
        tx_data_r <= tx_s_r;
      end
    end
  end

  // RX pop into a one-entry output register; contents dropped on IDLE entry
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_data_drain <= 1'b0;
      rx_m_valid    <= 1'b0;
      rx_m_l        <= '0;
      rx_m_r        <= '0;
    end else begin
      rx_data_drain <= rx_pop;
      if (rx_pop) begin
        rx_m_l <= rx_data_l;
        rx_m_r <= rx_data_r;
      end
      if (state_n == S_IDLE) rx_m_valid <= 1'b0;
      else if (rx_pop)       rx_m_valid <= 1'b1;
      else if (rx_consume)   rx_m_valid <= 1'b0;
    end
  end

  // Underrun/overrun edge counters: saturating, cleared only by start
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_emp_q     <= 1'b0;
      rx_full_q    <= 1'b0;
      underrun_cnt <= '0;
      overrun_cnt  <= '0;
    end else begin
      tx_emp_q  <= tx_both_empty;
      rx_full_q <= rx_full_any;
      if (state == S_IDLE && start && !stop) begin
        underrun_cnt <= '0;
        overrun_cnt  <= '0;
      end else begin
        if (state == S_RUN && tx_both_empty && !tx_emp_q && underrun_cnt != '1)
          underrun_cnt <= underrun_cnt + 1'b1;
        if ((state == S_RUN || state == S_FLUSH) && rx_full_any && !rx_full_q &&
            overrun_cnt != '1)
          overrun_cnt <= overrun_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iis_stream_ctrl.sv
// Directed bench for iis_stream_ctrl: start sequence, push/pop handshakes,
// counters with saturation, flush timeout, stop/start priority, async reset.
module tb_iis_stream_ctrl;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rstn, start, stop, busy;
  logic [2:0] state_o;
  logic tx_s_valid, tx_s_ready, rx_m_valid, rx_m_ready;
  logic [31:0] tx_s_l, tx_s_r, rx_m_l, rx_m_r;
  logic tx_data_fill, tx_data_clear, rx_data_drain, rx_data_clear, enable_o;
  logic [31:0] tx_data_l, tx_data_r, rx_data_l, rx_data_r;
  logic tx_data_l_full, tx_data_r_full, tx_data_l_empty, tx_data_r_empty;
  logic rx_data_l_empty, rx_data_r_empty, rx_data_l_full, rx_data_r_full;
  logic [CW-1:0] underrun_cnt, overrun_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  iis_stream_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .busy(busy), .state_o(state_o),
    .tx_s_valid(tx_s_valid), .tx_s_ready(tx_s_ready), .tx_s_l(tx_s_l), .tx_s_r(tx_s_r),
    .rx_m_valid(rx_m_valid), .rx_m_ready(rx_m_ready), .rx_m_l(rx_m_l), .rx_m_r(rx_m_r),
    .tx_data_fill(tx_data_fill), .tx_data_clear(tx_data_clear),
    .tx_data_l(tx_data_l), .tx_data_r(tx_data_r),
    .tx_data_l_full(tx_data_l_full), .tx_data_r_full(tx_data_r_full),
    .tx_data_l_empty(tx_data_l_empty), .tx_data_r_empty(tx_data_r_empty),
    .rx_data_drain(rx_data_drain), .rx_data_clear(rx_data_clear),
    .rx_data_l(rx_data_l), .rx_data_r(rx_data_r),
    .rx_data_l_empty(rx_data_l_empty), .rx_data_r_empty(rx_data_r_empty),
    .rx_data_l_full(rx_data_l_full), .rx_data_r_full(rx_data_r_full),
    .enable_o(enable_o), .underrun_cnt(underrun_cnt), .overrun_cnt(overrun_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 2 time units after the rising edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rstn = 1'b1; start = 0; stop = 0; tx_s_valid = 0; tx_s_l = 0; tx_s_r = 0;
    rx_m_ready = 0; tx_data_l_full = 0; tx_data_r_full = 0;
    tx_data_l_empty = 1; tx_data_r_empty = 1; rx_data_l = 0; rx_data_r = 0;
    rx_data_l_empty = 1; rx_data_r_empty = 1; rx_data_l_full = 0; rx_data_r_full = 0;
    #1 rstn = 1'b0;
    #2;
    chk("rst_state", state_o, 0);
    chk("rst_txclr", tx_data_clear, 1);
    chk("rst_rxclr", rx_data_clear, 1);
    chk("rst_en", enable_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fill", tx_data_fill, 0);
    chk("rst_drain", rx_data_drain, 0);
    chk("rst_rxv", rx_m_valid, 0);
    chk("rst_unr", underrun_cnt, 0);
    #19 rstn = 1'b1;
    cyc();

    // Start sequence: four cycles of CLEAR, then PREFILL
    start = 1; tx_data_l_empty = 0; tx_data_r_empty = 0;
    cyc(); start = 0;
    chk("clr_state", state_o, 1);
    chk("clr_busy", busy, 1);
    cyc(); cyc(); cyc();
    chk("clr_state4", state_o, 1);
    chk("clr_hold4", tx_data_clear, 1);
    tx_s_valid = 1; tx_s_l = 32'h11111111; tx_s_r = 32'h22222222;
    cyc();
    chk("pf_state", state_o, 2);
    chk("pf_clr", tx_data_clear, 0);
    chk("pf_rxclr", rx_data_clear, 0);
    chk("pf_ready", tx_s_ready, 1);
    chk("pf_en", enable_o, 0);
    cyc();
    chk("pf_fill1", tx_data_fill, 1);
    chk("pf_data1", tx_data_l, 32'h11111111);
    chk("pf_rdy_gap", tx_s_ready, 0);
    chk("pf_en1", enable_o, 0);
    tx_s_l = 32'h33333333; tx_s_r = 32'h44444444;
    cyc();
    chk("pf_fill0", tx_data_fill, 0);
    chk("pf_ready2", tx_s_ready, 1);
    cyc();
    chk("pf_fill2", tx_data_fill, 1);
    chk("pf_data2", tx_data_l, 32'h33333333);
    chk("run_state", state_o, 3);
    chk("run_en", enable_o, 1);

    // TX full back-pressure, then release
    tx_data_l_full = 1;
    cyc();
    chk("full_fill0", tx_data_fill, 0);
    chk("full_ready", tx_s_ready, 0);
    cyc();
    chk("full_nofill", tx_data_fill, 0);
    tx_s_l = 32'hB77BEFDF; tx_s_r = 32'hFBF7DEED; tx_data_l_full = 0;
    #1 chk("unfull_ready", tx_s_ready, 1);
    cyc();
    chk("unfull_fill", tx_data_fill, 1);
    chk("unfull_l", tx_data_l, 32'hB77BEFDF);
    chk("unfull_r", tx_data_r, 32'hFBF7DEED);
    tx_s_valid = 0;
    cyc();
    chk("txidle_fill", tx_data_fill, 0);

    // RX pop with consumer stalled, then released
    rx_data_l = 32'h48841020; rx_data_r = 32'h13572468;
    rx_data_l_empty = 0; rx_data_r_empty = 0;
    cyc();
    chk("rx_drain1", rx_data_drain, 1);
    chk("rx_v1", rx_m_valid, 1);
    chk("rx_l1", rx_m_l, 32'h48841020);
    rx_data_l = 32'hDEADBEEF;
    cyc();
    chk("rx_stall_dr", rx_data_drain, 0);
    chk("rx_stall_v", rx_m_valid, 1);
    chk("rx_stall_l", rx_m_l, 32'h48841020);
    cyc();
    chk("rx_stall_dr2", rx_data_drain, 0);
    chk("rx_stall_l2", rx_m_l, 32'h48841020);
    chk("rx_stall_r2", rx_m_r, 32'h13572468);
    rx_m_ready = 1;
    cyc();
    chk("rx_drain2", rx_data_drain, 1);
    chk("rx_l2", rx_m_l, 32'hDEADBEEF);
    cyc();
    chk("rx_gap", rx_data_drain, 0);
    chk("rx_gap_v", rx_m_valid, 0);
    cyc();
    chk("rx_drain3", rx_data_drain, 1);
    rx_data_l_empty = 1; rx_data_r_empty = 1;
    cyc();
    chk("rx_done_dr", rx_data_drain, 0);
    chk("rx_done_v", rx_m_valid, 0);

    // Underrun edge count and saturation
    tx_data_l_empty = 1; tx_data_r_empty = 1;
    cyc();
    chk("unr_1", underrun_cnt, 1);
    cyc();
    chk("unr_hold", underrun_cnt, 1);
    repeat (10) begin
      tx_data_l_empty = 0; cyc(); tx_data_l_empty = 1; cyc();
    end
    chk("unr_11", underrun_cnt, 11);
    repeat (290) begin
      tx_data_l_empty = 0; cyc(); tx_data_l_empty = 1; cyc();
    end
    chk("unr_sat", underrun_cnt, 8'hFF);
    tx_data_l_empty = 0; tx_data_r_empty = 0;

    // Overrun edges on either full flag
    rx_data_l_full = 1; cyc(); rx_data_l_full = 0;
    chk("ovr_1", overrun_cnt, 1);
    cyc(); rx_data_r_full = 1; cyc(); rx_data_r_full = 0;
    chk("ovr_2", overrun_cnt, 2);

    // Stop with TX never draining: FLUSH runs to the timeout
    tx_s_valid = 1; stop = 1;
    cyc(); stop = 0;
    chk("fl_state", state_o, 4);
    chk("fl_en", enable_o, 1);
    chk("fl_ready", tx_s_ready, 0);
    repeat (65534) cyc();
    chk("fl_last", state_o, 4);
    cyc();
    chk("fl_idle", state_o, 0);
    chk("fl_en0", enable_o, 0);
    chk("fl_busy0", busy, 0);
    chk("idle_unr_hold", underrun_cnt, 8'hFF);
    chk("idle_ovr_hold", overrun_cnt, 2);
    tx_s_valid = 0;

    // start+stop together: stop wins
    start = 1; stop = 1;
    cyc(); start = 0; stop = 0;
    chk("ss_idle", state_o, 0);
    // start clears counters; stop in CLEAR aborts
    start = 1;
    cyc(); start = 0;
    chk("st_clear", state_o, 1);
    chk("st_unr0", underrun_cnt, 0);
    chk("st_ovr0", overrun_cnt, 0);
    stop = 1;
    cyc(); stop = 0;
    chk("stop_clr", state_o, 0);

    // PREFILL cut short by a full TX FIFO
    start = 1;
    cyc(); start = 0;
    repeat (4) cyc();
    chk("pf2_state", state_o, 2);
    tx_data_r_full = 1;
    cyc();
    chk("pf2_run", state_o, 3);
    chk("pf2_nofill", tx_data_fill, 0);

    // Async reset in RUN with a fill pulse in flight
    tx_data_r_full = 0; tx_s_valid = 1; tx_s_l = 32'hCAFEF00D;
    cyc();
    chk("ar_fill", tx_data_fill, 1);
    #1 rstn = 0;
    #1;
    chk("ar_fill0", tx_data_fill, 0);
    chk("ar_state", state_o, 0);
    chk("ar_clr", tx_data_clear, 1);
    chk("ar_en", enable_o, 0);
    chk("ar_data", tx_data_l, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
